// File: rtl/serial_mod_n_checker_pkg.sv
// Shared definitions for the serial modulo-N checker.
// Holds the frame state encoding and the default widths used by the
// checker top, its arithmetic core and the stream interface.
package serial_mod_pkg;

  localparam int DW_DEFAULT       = 4;
  localparam int MAX_BITS_DEFAULT = 32;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/serial_mod_n_checker_if.sv
// Serial bit-stream interface between the deserialiser front end and the
// modulo-N checker.
//   divisor     : modulus N, only meaningful on the frame-start beat
//   bit_valid   : qualifies bit_in, frame_start and frame_last
//   bit_in      : serial data bit, MSB first
//   frame_start : first bit of a frame
//   frame_last  : final bit of a frame
// master drives the stream, slave (the checker) consumes it.
interface serial_mod_n_checker_if #(
  parameter int DW = serial_mod_pkg::DW_DEFAULT
);

  logic [DW-1:0] divisor;
  logic          bit_valid;
  logic          bit_in;
  logic          frame_start;
  logic          frame_last;

  modport master (
    output divisor,
    output bit_valid,
    output bit_in,
    output frame_start,
    output frame_last
  );

  modport slave (
    input divisor,
    input bit_valid,
    input bit_in,
    input frame_start,
    input frame_last
  );

endinterface

// File: rtl/serial_mod_n_checker_mod_step.sv
// mod_step: one-bit step of an MSB-first running remainder modulo n.
// Ports:
//   base     in  DW  remainder before this bit (must be < n)
//   bit_in   in  1   incoming data bit
//   n        in  DW  modulus; 0 means "no modulus", result forced to 0
//   next_rem out DW  (2*base + bit_in) mod n
//   zero     out 1   next_rem is 0 and n is a real modulus
// Because base < n, t = 2*base + bit_in < 2n, so one conditional
// subtraction completes the reduction.
module mod_step #(
  parameter int DW = serial_mod_pkg::DW_DEFAULT
) (
  input  logic [DW-1:0] base,
  input  logic          bit_in,
  input  logic [DW-1:0] n,
  output logic [DW-1:0] next_rem,
  output logic          zero
);

  logic [DW:0] t_s;
  logic [DW:0] n_ext_s;

  // Doubling plus bit, then a single conditional subtraction.
  always_comb begin
    t_s      = {base, bit_in};
    n_ext_s  = {1'b0, n};
    next_rem = {DW{1'b0}};
    zero     = 1'b0;
    if (n == {DW{1'b0}}) begin
      next_rem = {DW{1'b0}};
      zero     = 1'b0;
    end else if (t_s >= n_ext_s) begin
      next_rem = DW'(t_s - n_ext_s);
      zero     = (DW'(t_s - n_ext_s) == {DW{1'b0}});
    end else begin
      next_rem = t_s[DW-1:0];
      zero     = (t_s[DW-1:0] == {DW{1'b0}});
    end
  end

endmodule

// File: rtl/serial_mod_n_checker.sv
// serial_mod_n_checker: tracks the running remainder of an MSB-first framed
// bit stream modulo a divisor latched at frame start.
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   bus        in   serial_mod_n_checker_if.slave (divisor, bit_valid,
//                   bit_in, frame_start, frame_last)
//   remainder  out  DW   registered running remainder
//   div_now    out  1    combinational: value including current bit divisible
//   div_flag   out  1    registered verdict of last completed frame
//   frame_done out  1    pulse the cycle after a last beat
//   frame_len  out  bits in current/last frame, saturating at MAX_BITS
//   busy       out  1    frame open
//   err_div    out  1    frame opened with divisor 0, sticky to next start
// Optional (macro SERIAL_MOD_STATS_EN):
//   stats_clr    in   1   clear both frame counters (wins over increment)
//   frames_total out  16  count of frame_done pulses
//   frames_div   out  16  count of frame_done pulses with div_flag set
module serial_mod_n_checker
  import serial_mod_pkg::*;
#(
  parameter int DW       = DW_DEFAULT,
  parameter int MAX_BITS = MAX_BITS_DEFAULT,
  localparam int LW      = $clog2(MAX_BITS + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  serial_mod_n_checker_if.slave   bus,
  output logic [DW-1:0]           remainder,
  output logic                    div_now,
  output logic                    div_flag,
  output logic                    frame_done,
  output logic [LW-1:0]           frame_len,
  output logic                    busy,
  output logic                    err_div
`ifdef SERIAL_MOD_STATS_EN
  ,
  input  logic                    stats_clr,
  output logic [15:0]             frames_total,
  output logic [15:0]             frames_div
`endif
);

  state_t        state_r;
  state_t        state_s;
  logic [DW-1:0] n_q_r;
  logic [DW-1:0] rem_r;
  logic [LW-1:0] len_r;
  logic          flag_r;
  logic          done_r;
  logic          err_r;

  logic          accepted_s;
  logic [DW-1:0] n_s;
  logic [DW-1:0] base_s;
  logic [DW-1:0] next_rem_s;
  logic          zero_s;

  mod_step #(.DW(DW)) u_step (
    .base     (base_s),
    .bit_in   (bus.bit_in),
    .n        (n_s),
    .next_rem (next_rem_s),
    .zero     (zero_s)
  );

  // Beat acceptance, divisor/base selection and next-state decode.
  always_comb begin
    accepted_s = bus.bit_valid && ((state_r == ST_ACTIVE) || bus.frame_start);
    n_s        = n_q_r;
    base_s     = rem_r;
    state_s    = state_r;

    // A start beat uses the live divisor and restarts from zero.
    if (bus.frame_start) begin
      n_s    = bus.divisor;
      base_s = {DW{1'b0}};
    end else begin
      n_s    = n_q_r;
      base_s = rem_r;
    end

    case (state_r)
      ST_IDLE: begin
        // Start together with last is a single-bit frame: stay idle.
        if (accepted_s && !bus.frame_last) begin
          state_s = ST_ACTIVE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (accepted_s && bus.frame_last) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_ACTIVE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath registers: remainder, length, latched divisor and verdicts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_q_r  <= {DW{1'b0}};
      rem_r  <= {DW{1'b0}};
      len_r  <= {LW{1'b0}};
      flag_r <= 1'b0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      done_r <= accepted_s && bus.frame_last;
      if (accepted_s) begin
        rem_r <= next_rem_s;
        if (bus.frame_start) begin
          n_q_r <= bus.divisor;
          err_r <= (bus.divisor == {DW{1'b0}});
          len_r <= LW'(1);
        end else if (len_r != LW'(MAX_BITS)) begin
          len_r <= len_r + LW'(1);
        end
        if (bus.frame_last) begin
          flag_r <= zero_s;
        end
      end
    end
  end

`ifdef SERIAL_MOD_STATS_EN
  logic [15:0] tot_r;
  logic [15:0] dv_r;

  // Frame statistics; clear has priority over counting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tot_r <= 16'd0;
      dv_r  <= 16'd0;
    end else if (stats_clr) begin
      tot_r <= 16'd0;
      dv_r  <= 16'd0;
    end else if (done_r) begin
      tot_r <= tot_r + 16'd1;
      if (flag_r) begin
        dv_r <= dv_r + 16'd1;
      end
    end
  end

  assign frames_total = tot_r;
  assign frames_div   = dv_r;
`endif

  assign remainder  = rem_r;
  assign div_now    = accepted_s && zero_s;
  assign div_flag   = flag_r;
  assign frame_done = done_r;
  assign frame_len  = len_r;
  assign busy       = (state_r == ST_ACTIVE);
  assign err_div    = err_r;

endmodule

// File: tb/tb_serial_mod_n_checker.sv
// Randomised self-checking bench for serial_mod_n_checker. The reference
// model keeps the whole frame value as an integer and takes value % N.
module tb_serial_mod_n_checker;

  logic clk;
  logic reset;

  serial_mod_n_checker_if #(.DW(4)) bus ();

  logic [3:0] remainder;
  logic       div_now;
  logic       div_flag;
  logic       frame_done;
  logic [5:0] frame_len;
  logic       busy;
  logic       err_div;
`ifdef SERIAL_MOD_STATS_EN
  logic        stats_clr;
  logic [15:0] frames_total;
  logic [15:0] frames_div;
`endif

  serial_mod_n_checker #(.DW(4), .MAX_BITS(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .remainder  (remainder),
    .div_now    (div_now),
    .div_flag   (div_flag),
    .frame_done (frame_done),
    .frame_len  (frame_len),
    .busy       (busy),
    .err_div    (err_div)
`ifdef SERIAL_MOD_STATS_EN
    ,
    .stats_clr    (stats_clr),
    .frames_total (frames_total),
    .frames_div   (frames_div)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  bit              m_active;
  longint unsigned m_val;
  int              m_n;
  int              m_len;
  bit              m_flag;
  bit              m_done;
  bit              m_err;
  int              m_tot;
  int              m_dv;
  bit              clr;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_val = 0; m_n = 0; m_len = 0;
    m_flag = 0; m_done = 0; m_err = 0; m_tot = 0; m_dv = 0;
  endtask

  task automatic check_regs();
    longint unsigned exp_rem;
    exp_rem = (m_n == 0) ? 0 : (m_val % longint'(m_n));
    check_val("remainder", remainder, exp_rem);
    check_val("frame_len", frame_len, m_len);
    check_val("busy", busy, m_active);
    check_val("frame_done", frame_done, m_done);
    check_val("div_flag", div_flag, m_flag);
    check_val("err_div", err_div, m_err);
`ifdef SERIAL_MOD_STATS_EN
    check_val("frames_total", frames_total, m_tot);
    check_val("frames_div", frames_div, m_dv);
`endif
  endtask

  // One clock: drive inputs, check div_now, clock, then check registers.
  task automatic step(input bit v, input bit b, input bit s, input bit l, input logic [3:0] d);
    bit              acc;
    int              n;
    longint unsigned nv;
    bit              exp_dn;
    bit              old_done;
    bit              old_flag;
    bus.bit_valid   = v;
    bus.bit_in      = b;
    bus.frame_start = s;
    bus.frame_last  = l;
    bus.divisor     = d;
`ifdef SERIAL_MOD_STATS_EN
    stats_clr = clr;
`endif
    #1;
    acc    = v && (m_active || s);
    n      = s ? int'(d) : m_n;
    nv     = s ? longint'(b) : (m_val * 2 + longint'(b));
    exp_dn = acc && (n != 0) && ((nv % longint'((n == 0) ? 1 : n)) == 0);
    check_val("div_now", div_now, exp_dn);
    @(posedge clk);
    #1;
    old_done = m_done;
    old_flag = m_flag;
    if (clr) begin
      m_tot = 0; m_dv = 0;
    end else if (old_done) begin
      m_tot = (m_tot + 1) % 65536;
      if (old_flag) m_dv = (m_dv + 1) % 65536;
    end
    if (acc) begin
      m_val = nv;
      if (s) begin
        m_n   = n;
        m_err = (d == 4'd0);
        m_len = 1;
      end else if (m_len < 32) begin
        m_len = m_len + 1;
      end
      m_done = l;
      if (l) m_flag = exp_dn;
      m_active = !l;
    end else begin
      m_done = 0;
    end
    check_regs();
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end
  endtask

  // gap < 0: random 0..3 idle beats; mid_div < 0: keep n; mid_div > 15: random.
  task automatic send_frame(input longint unsigned val, input int len, input int n,
                            input int gap, input int mid_div, input bit with_last);
    logic [3:0] d;
    for (int i = 0; i < len; i++) begin
      if (i > 0) idle((gap < 0) ? $urandom_range(0, 3) : gap);
      if (i == 0 || mid_div < 0) d = 4'(n);
      else if (mid_div > 15) d = 4'($urandom_range(0, 15));
      else d = 4'(mid_div);
      step(1'b1, val[len-1-i], i == 0, with_last && (i == len - 1), d);
    end
  endtask

  initial begin
    longint unsigned rv;
    int              rl;
    int              rn;
    clr             = 0;
    bus.bit_valid   = 1'b0;
    bus.bit_in      = 1'b0;
    bus.frame_start = 1'b0;
    bus.frame_last  = 1'b0;
    bus.divisor     = 4'd0;
`ifdef SERIAL_MOD_STATS_EN
    stats_clr = 1'b0;
`endif
    model_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_regs();
    reset = 1'b0;
    idle(2);

    // N=3, 10101 -> divisible; N=5 -> remainder 1.
    send_frame(64'd21, 5, 3, 0, -1, 1'b1);
    idle(1);
    send_frame(64'd21, 5, 5, 0, -1, 1'b1);
    idle(2);
    // N=7 with gaps and divisor changed mid-frame.
    send_frame(64'd21, 5, 7, 2, 4, 1'b1);
    idle(1);
    // Back-to-back frames with no bubble.
    send_frame(64'd6, 3, 3, 0, -1, 1'b1);
    send_frame(64'd11, 4, 4, 0, -1, 1'b1);
    idle(2);

    // Reset after three bits of a frame, asynchronous to the clock.
    send_frame(64'd13, 3, 3, 0, -1, 1'b0);
    bus.bit_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_regs();
    @(posedge clk);
    #1;
    check_regs();
    reset = 1'b0;
    idle(1);
    send_frame(64'd9, 4, 3, 0, -1, 1'b1);
    idle(1);

    // Divisor zero, then a normal frame clears err_div.
    send_frame(64'd15, 4, 0, 0, -1, 1'b1);
    idle(1);
    send_frame(64'd5, 3, 1, 0, -1, 1'b1);
    idle(1);

    // Randomised frames, including restarts, long frames and stats clears.
    for (int f = 0; f < 60; f++) begin
      rl = $urandom_range(1, 60);
      rv = {32'($urandom), 32'($urandom)};
      rv = rv & ((64'd1 << rl) - 64'd1);
      rn = $urandom_range(0, 15);
      clr = ($urandom_range(0, 9) == 0);
      send_frame(rv, rl, rn, -1, ($urandom_range(0, 1) == 1) ? 16 : -1,
                 $urandom_range(0, 5) != 0);
      clr = 0;
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
